// File: rtl/tetris_cmd_pkg.sv
// Shared command codes and scheduler state encoding for the Tetris move path.
// The CMD_* codes are also decoded by Tetris_design, so keep them in sync.
package tetris_cmd_pkg;

  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_ROTATE = 3'd3;
  localparam logic [2:0] CMD_DOWN   = 3'd4;
  localparam logic [2:0] CMD_DROP   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } sched_state_t;

  // Request vectors are indexed by (code - 1): LEFT, RIGHT, ROTATE, DOWN, DROP.
  function automatic logic [2:0] pick_cmd(input logic [4:0] req);
    logic [2:0] code;
    code = CMD_NONE;
    if (req[4])      code = CMD_DROP;
    else if (req[3]) code = CMD_DOWN;
    else if (req[2]) code = CMD_ROTATE;
    else if (req[0]) code = CMD_LEFT;
    else if (req[1]) code = CMD_RIGHT;
    return code;
  endfunction

  function automatic logic [4:0] cmd_onehot(input logic [2:0] code);
    logic [4:0] hot;
    hot = '0;
    case (code)
      CMD_LEFT:   hot = 5'b00001;
      CMD_RIGHT:  hot = 5'b00010;
      CMD_ROTATE: hot = 5'b00100;
      CMD_DOWN:   hot = 5'b01000;
      CMD_DROP:   hot = 5'b10000;
      default:    hot = '0;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/tetris_gravity_timer.sv
// Free-running gravity counter producing a one-cycle tick every GRAV_DIV
// (or FAST_DIV while fast=1) cycles of run; clear holds it at zero.
module tetris_gravity_timer #(
  parameter int unsigned GRAV_DIV = 50_000_000,
  parameter int unsigned FAST_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  input  logic fast,
  output logic tick
);

  logic [31:0] cnt;
  logic [31:0] last;

  // Using >= lets a switch to the shorter period fire at once when the count is already past it.
  assign last = fast ? 32'(FAST_DIV - 1) : 32'(GRAV_DIV - 1);
  assign tick = run && !clear && (cnt >= last);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 32'd1;
    end
  end

endmodule

// File: rtl/tetris_cmd_scheduler.sv
// Serializes button pulses and gravity ticks into one move command at a time
// for the game core, with fixed priority, request coalescing and a post-accept gap.
module tetris_cmd_scheduler
  import tetris_cmd_pkg::*;
#(
  parameter int unsigned GRAV_DIV = 50_000_000,
  parameter int unsigned FAST_DIV = 5_000_000,
  parameter int unsigned GAP      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_run,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       rotate,
  input  logic       move_tobottom,
  input  logic       move_fast,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  input  logic       cmd_ready,
  output logic       busy,
  output logic [7:0] coalesce_cnt
);

  localparam int HW = (GAP > 1) ? $clog2(GAP) : 1;

  sched_state_t    state, state_next;
  logic [2:0]      code_q, code_next;
  logic [4:0]      pend, pulse, req, granted, merged;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      merge_n;
  logic [8:0]      coal_sum;
  logic            accept;
  logic            grav_tick;

  tetris_gravity_timer #(
    .GRAV_DIV(GRAV_DIV),
    .FAST_DIV(FAST_DIV)
  ) u_gravity (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (game_run),
    .clear(!game_run),
    .fast (move_fast),
    .tick (grav_tick)
  );

  assign pulse   = {move_tobottom, grav_tick, rotate, move_right, move_left};
  assign req     = pend | pulse;
  assign accept  = (state == ST_ISSUE) && cmd_ready;
  assign granted = accept ? cmd_onehot(code_q) : '0;
  assign merged  = pulse & pend & ~granted;

  assign cmd_valid = (state == ST_ISSUE);
  assign cmd_code  = code_q;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    merge_n = '0;
    for (int i = 0; i < 5; i++) begin
      merge_n = merge_n + {2'b00, merged[i]};
    end
    coal_sum = {1'b0, coalesce_cnt} + {6'd0, merge_n};
  end

  // IDLE looks at live pulses too, so a fresh request is offered on the very next cycle.
  always_comb begin
    state_next = state;
    code_next  = code_q;
    if (!game_run) begin
      state_next = ST_IDLE;
      code_next  = CMD_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state_next = ST_ISSUE;
            code_next  = pick_cmd(req);
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            code_next  = CMD_NONE;
            state_next = (GAP > 0) ? ST_HOLDOFF : ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == HW'(GAP - 1)) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          code_next  = CMD_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      code_q       <= CMD_NONE;
      pend         <= '0;
      hold_cnt     <= '0;
      coalesce_cnt <= '0;
    end else begin
      state    <= state_next;
      code_q   <= code_next;
      hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + 1'b1 : '0;
      if (!game_run) begin
        pend <= '0;
      end else begin
        pend         <= (pend & ~granted) | pulse;
        coalesce_cnt <= coal_sum[8] ? 8'hFF : coal_sum[7:0];
      end
    end
  end

endmodule
